step_controller: RTL
====================

# step_controller

Run/step sequencer for the CPU datapath. It runs on the 5 MHz oscillator clock and produces a per-cycle clock enable from the step button, the run/step and instruction/cycle switches, and a PC breakpoint. The enable lets the datapath free-run, execute one microcycle, or execute one complete instruction. It halts on a breakpoint and holds the halt until the operator acts.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a button/switch change is accepted (10 ms at 5 MHz).
- ADDR_WIDTH, 16: width of PC and breakpoint address.

Ports (one clock; reset is synchronous and active-high):
- i_oszClk  in  1  design clock; all state changes on its rising edge.
- i_reset  in  1  synchronous reset, active high.
- i_btnStep  in  1  raw step button, asynchronous, 1 = pressed.
- i_swInstrNCycle  in  1  raw switch: 1 = instruction step, 0 = cycle step.
- i_swStepNRun  in  1  raw switch: 1 = step mode, 0 = run mode.
- i_swEnableBreakpoint  in  1  raw switch: 1 = breakpoint armed.
- i_breakpointAddress  in  ADDR_WIDTH  breakpoint PC, quasi-static.
- i_pc  in  ADDR_WIDTH  datapath PC. It is valid (address of the next instruction) in any cycle where i_instrDone=1.
- i_instrDone  in  1  from control unit: the current microcycle is the last one of its instruction.
- o_cpuEnable  out  1  datapath clock enable for the current cycle.
- o_halted  out  1  1 when in HALT.
- o_breakHit  out  1  sticky flag: halted by breakpoint.

## Operation
- **Input synchronisation.** All four raw inputs pass through a 2-flop synchroniser. Each synchronised input has its own debouncer: a counter that resets whenever the synchronised value equals the debounced value. The debounced value takes the synchronised value when the counter reaches DEBOUNCE_CYCLES.
- **Step request.** stepReq is a one-cycle pulse on each rising edge of debounced btnStep. Release edges are ignored.
- **Instruction boundary.** boundary = o_cpuEnable & i_instrDone.
- **States** (registered, Moore): HALT, RUN, STEP_CYCLE, STEP_INSTR.
- **o_cpuEnable / o_halted.** o_cpuEnable = 1 in RUN, STEP_CYCLE and STEP_INSTR. o_halted = 1 only in HALT.
- **HALT transitions:**
  - stepReq & instrNCycle=0 → STEP_CYCLE.
  - stepReq & instrNCycle=1 → STEP_INSTR.
  - otherwise stepNRun=0 & !breakHit → RUN.
  - else stay in HALT.
  - stepReq always clears breakHit.
- **STEP_CYCLE** → HALT unconditionally, giving exactly one enable cycle.
- **STEP_INSTR** → HALT on boundary; otherwise stay. The breakpoint is not evaluated while stepping.
- **RUN transitions:**
  - boundary & bpEn & i_pc==i_breakpointAddress → HALT, and breakHit is set.
  - boundary & stepNRun=1 → HALT. Switching to step mode always completes the current instruction first.
  - Breakpoint takes priority when both conditions hold.
  - stepReq is ignored in RUN.
- **Clearing breakHit:**
  - Cleared by stepReq, by debounced bpEn going 0, or by reset.
  - Set has priority over clear in the same cycle.
  - After a step clears breakHit in run mode, the controller executes that step, returns to HALT, then enters RUN on the following cycle.
- **Address compare.** Full ADDR_WIDTH equality, unsigned. No masking.
- **Reset.** State=HALT, breakHit=0, synchroniser and debounced values=0, counters=0. Outputs after reset: o_cpuEnable=0, o_halted=1, o_breakHit=0.
- **Reset mid-instruction.** The instruction is abandoned. The datapath receives its own reset; this block does not complete the instruction.

## Timing
- Press-to-enable latency in HALT: DEBOUNCE_CYCLES+3 cycles after the raw button becomes stable high, with zero jitter.
- A bounce shorter than DEBOUNCE_CYCLES produces no stepReq.
- Switch change to run: debounced stepNRun=0 at cycle N gives state RUN and o_cpuEnable=1 at cycle N+1.
- The datapath samples o_cpuEnable in the same cycle it is high. i_instrDone must be combinationally valid in that cycle.
- Breakpoint/step-mode stop: the boundary cycle is the last enabled cycle, and o_cpuEnable=0 from the next cycle.
- A stepReq arriving while not in HALT is dropped, not queued.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- **Reset.** Assert i_reset for 2 cycles with all switches 0 → o_halted=1, o_cpuEnable=0, o_breakHit=0. One cycle after release, state is RUN and o_cpuEnable=1.
- **Cycle step.** stepNRun=1, instrNCycle=0; hold the button for 10 cycles → o_cpuEnable high for exactly 1 cycle, 7 cycles after the press. A 3-cycle glitch press gives no enable.
- **Instruction step.** instrNCycle=1; drive i_instrDone on the 3rd enabled cycle → exactly 3 enable cycles, then HALT. A second press during those cycles is ignored.
- **Breakpoint.** Run with bpEn=1, i_breakpointAddress=16'h0028; present i_pc=16'h0028 with i_instrDone=1 → enable drops the next cycle and o_breakHit=1. Remaining in HALT for 20 cycles keeps o_halted=1.
- **Resume.** From a breakpoint halt, press step with instrNCycle=1 → breakHit clears, one instruction executes, HALT, then RUN. Separately, clearing bpEn also resumes RUN.
- **Run-to-step with mid-run reset.** Flip stepNRun to 1 mid-instruction → enable continues until i_instrDone, then halts. Assert i_reset during STEP_INSTR → o_cpuEnable=0 the next cycle.

Source files
------------

// File: rtl/step_controller.sv
// Run/step sequencer: turns debounced operator controls and a PC breakpoint into
// a per-cycle datapath clock enable (free run, single microcycle, single instruction).
module step_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned ADDR_WIDTH      = 16
) (
    input  logic                  i_oszClk,
    input  logic                  i_reset,
    input  logic                  i_btnStep,
    input  logic                  i_swInstrNCycle,
    input  logic                  i_swStepNRun,
    input  logic                  i_swEnableBreakpoint,
    input  logic [ADDR_WIDTH-1:0] i_breakpointAddress,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_instrDone,
    output logic                  o_cpuEnable,
    output logic                  o_halted,
    output logic                  o_breakHit
);

    localparam int unsigned NUM_IN = 4;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam int unsigned IDX_STEP  = 0;
    localparam int unsigned IDX_INSTR = 1;
    localparam int unsigned IDX_SNR   = 2;
    localparam int unsigned IDX_BPEN  = 3;

    localparam logic [1:0] ST_HALT       = 2'd0;
    localparam logic [1:0] ST_RUN        = 2'd1;
    localparam logic [1:0] ST_STEP_CYCLE = 2'd2;
    localparam logic [1:0] ST_STEP_INSTR = 2'd3;

    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] sync1_q, sync2_q;
    logic [NUM_IN-1:0] deb_q, deb_d;
    logic [CNT_W-1:0]  cnt_q [NUM_IN];
    logic [CNT_W-1:0]  cnt_d [NUM_IN];
    logic              btn_prev_q;
    logic [1:0]        state_q, state_d;
    logic              break_hit_q, break_hit_d;

    logic step_req;
    logic boundary;
    logic bp_match;

    assign raw = {i_swEnableBreakpoint, i_swStepNRun, i_swInstrNCycle, i_btnStep};

    // Counter restarts whenever the synchronised input agrees with the accepted value,
    // so only an uninterrupted run of DEBOUNCE_CYCLES disagreeing samples is accepted.
    always_comb begin
        deb_d = deb_q;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] + 1'b1 == CNT_W'(DEBOUNCE_CYCLES)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign step_req    = deb_q[IDX_STEP] & ~btn_prev_q;
    assign o_cpuEnable = (state_q != ST_HALT);
    assign o_halted    = (state_q == ST_HALT);
    assign o_breakHit  = break_hit_q;
    assign boundary    = o_cpuEnable & i_instrDone;
    assign bp_match    = deb_q[IDX_BPEN] & (i_pc == i_breakpointAddress);

    always_comb begin
        state_d     = state_q;
        break_hit_d = break_hit_q;
        if (step_req || !deb_q[IDX_BPEN]) begin
            break_hit_d = 1'b0;
        end
        case (state_q)
            ST_HALT: begin
                if (step_req) begin
                    state_d = deb_q[IDX_INSTR] ? ST_STEP_INSTR : ST_STEP_CYCLE;
                end else if (!deb_q[IDX_SNR] && !break_hit_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP_CYCLE: state_d = ST_HALT;
            ST_STEP_INSTR: begin
                if (boundary) begin
                    state_d = ST_HALT;
                end
            end
            ST_RUN: begin
                // Breakpoint wins over a pending step-mode stop; set overrides any clear.
                if (boundary && bp_match) begin
                    state_d     = ST_HALT;
                    break_hit_d = 1'b1;
                end else if (boundary && deb_q[IDX_SNR]) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge i_oszClk) begin
        if (i_reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            cnt_q       <= '{default: '0};
            btn_prev_q  <= 1'b0;
            state_q     <= ST_HALT;
            break_hit_q <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            cnt_q       <= cnt_d;
            btn_prev_q  <= deb_q[IDX_STEP];
            state_q     <= state_d;
            break_hit_q <= break_hit_d;
        end
    end

endmodule
